// File: rtl/dbus_pkg.sv
// dbus_pkg: shared definitions for the 16-bit CPU data/instruction bus
// responder. Holds the responder FSM encoding, byte-lane strobe constants
// and the bus data width.
package dbus_pkg;

   localparam int DATA_W = 16;

   localparam logic [1:0] STB_HI   = 2'b10;
   localparam logic [1:0] STB_LO   = 2'b01;
   localparam logic [1:0] STB_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/dbus_ram_if.sv
// dbus_ram_if: cyc/stb/we/addr/dat/ack/err handshake between the CPU core
// (master) and a bus responder (slave). Signal names follow the responder's
// view: i_* are driven by the master, o_* by the responder.
interface dbus_ram_if;
   import dbus_pkg::*;

   logic              i_cyc;
   logic [1:0]        i_stb;
   logic              i_we;
   logic [31:0]       i_addr;
   logic [DATA_W-1:0] i_dat;
   logic [DATA_W-1:0] o_dat;
   logic              o_ack;
   logic              o_err;

   modport master (
      output i_cyc, i_stb, i_we, i_addr, i_dat,
      input  o_dat, o_ack, o_err
   );

   modport slave (
      input  i_cyc, i_stb, i_we, i_addr, i_dat,
      output o_dat, o_ack, o_err
   );

endinterface

// File: rtl/dbus_ram_array.sv
// dbus_ram_array: 2^ADDR_W x 16 storage with per-byte write enables and a
// registered read port. No reset on the storage or the read register so the
// array maps onto block RAM.
module dbus_ram_array
   import dbus_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              i_clk,
   input  logic [1:0]        i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_wrDat,
   input  logic              i_rdEn,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0] o_rdDat
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdDat_q;

   // Byte-lane writes and a synchronous read, in the block RAM template form.
   always_ff @(posedge i_clk) begin
      if (i_wrEn[1]) begin
         mem[i_wrAddr][15:8] <= i_wrDat[15:8];
      end
      if (i_wrEn[0]) begin
         mem[i_wrAddr][7:0] <= i_wrDat[7:0];
      end
      if (i_rdEn) begin
         rdDat_q <= mem[i_rdAddr];
      end
   end

   assign o_rdDat = rdDat_q;

endmodule

// File: rtl/dbus_ram.sv
// dbus_ram: on-chip RAM responder for the CPU's 16-bit bus. Decodes an
// address window, inserts WAIT wait states, writes strobed byte lanes and
// returns exactly one acknowledge per accepted request.
// Optional feature macro: DBUS_RAM_ERR_EN -- out-of-window accesses end
// with o_err instead of o_ack.
module dbus_ram
   import dbus_pkg::*;
#(
   parameter int          ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_0000,
   parameter int          WAIT   = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   dbus_ram_if.slave  bus
);

   localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   state_t            state_q;
   logic [3:0]        waitCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        stb_q;
   logic [DATA_W-1:0] dat_q;
   logic              inRange_q;
   logic              ack_q;
`ifdef DBUS_RAM_ERR_EN
   logic              err_q;
`endif

   logic              request;
   logic              inRangeNow;
   logic [ADDR_W-1:0] wordNow;
   logic              goAck;
   logic              respInRange;
   logic [ADDR_W-1:0] rdAddr;
   logic [1:0]        wrEn;
   logic [DATA_W-1:0] rdDat;
   logic              unusedAddrBit;

   assign request       = bus.i_cyc && (|bus.i_stb);
   assign inRangeNow    = (bus.i_addr[31:ADDR_W+1] == BASE[31:ADDR_W+1]);
   assign wordNow       = bus.i_addr[ADDR_W:1];
   assign unusedAddrBit = bus.i_addr[0];

   // Decide whether this edge enters ACK; that same edge performs the array
   // read, using the live address from IDLE or the latched one from WAIT.
   always_comb begin
      goAck       = 1'b0;
      respInRange = inRange_q;
      rdAddr      = addr_q;
      case (state_q)
         ST_IDLE: begin
            goAck       = request && (WAIT == 0);
            respInRange = inRangeNow;
            rdAddr      = wordNow;
         end
         ST_WAIT: begin
            goAck = bus.i_cyc && (waitCnt_q == 4'd0);
         end
         default: begin
            goAck = 1'b0;
         end
      endcase
   end

   // The write lands on the edge that closes the ACK cycle, so a reset or
   // abort before then leaves the array untouched.
   assign wrEn = (state_q == ST_ACK && we_q && inRange_q) ? stb_q : 2'b00;

   // Responder FSM: accept in IDLE, count wait states, one-cycle response.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         waitCnt_q <= 4'd0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         stb_q     <= 2'b00;
         dat_q     <= '0;
         inRange_q <= 1'b0;
         ack_q     <= 1'b0;
`ifdef DBUS_RAM_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
`ifdef DBUS_RAM_ERR_EN
         err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (request) begin
                  addr_q    <= wordNow;
                  we_q      <= bus.i_we;
                  stb_q     <= bus.i_stb;
                  dat_q     <= bus.i_dat;
                  inRange_q <= inRangeNow;
                  if (WAIT > 0) begin
                     waitCnt_q <= WAIT_LOAD;
                     state_q   <= ST_WAIT;
                  end else begin
                     state_q <= ST_ACK;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.i_cyc) begin
                  state_q <= ST_IDLE;
               end else if (waitCnt_q == 4'd0) begin
                  state_q <= ST_ACK;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
         if (goAck) begin
`ifdef DBUS_RAM_ERR_EN
            ack_q <= respInRange;
            err_q <= !respInRange;
`else
            ack_q <= 1'b1;
`endif
         end
      end
   end

   dbus_ram_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .i_clk    (i_clk),
      .i_wrEn   (wrEn),
      .i_wrAddr (addr_q),
      .i_wrDat  (dat_q),
      .i_rdEn   (goAck),
      .i_rdAddr (rdAddr),
      .o_rdDat  (rdDat)
   );

   assign bus.o_ack = ack_q;
   assign bus.o_dat = (ack_q && inRange_q) ? rdDat : '0;
`ifdef DBUS_RAM_ERR_EN
   assign bus.o_err = err_q;
`else
   assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_ram.sv
// tb_dbus_ram: scoreboard bench for dbus_ram. Two instances are exercised,
// one with no wait states and one with WAIT=3. Expected responses (kind,
// cycle, data) are queued at issue time and a per-instance monitor pops
// and compares them whenever the DUT responds.
module tb_dbus_ram;
   import dbus_pkg::*;

`ifdef DBUS_RAM_ERR_EN
   localparam bit OOR_ERR = 1'b1;
`else
   localparam bit OOR_ERR = 1'b0;
`endif

   typedef struct {
      bit          isErr;
      bit          chkDat;
      logic [15:0] dat;
      int          cyc;
   } exp_t;

   logic        clock;
   logic        reset;
   int          cycle;
   int          checks;
   int          errors;

   logic [1:0]  cyc;
   logic [1:0]  we;
   logic [1:0]  stb  [2];
   logic [31:0] addr [2];
   logic [15:0] wdat [2];
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [15:0] rdat [2];

   exp_t        expQ0 [$];
   exp_t        expQ1 [$];

   dbus_ram_if bus0 ();
   dbus_ram_if bus3 ();

   assign bus0.i_cyc  = cyc[0];
   assign bus0.i_stb  = stb[0];
   assign bus0.i_we   = we[0];
   assign bus0.i_addr = addr[0];
   assign bus0.i_dat  = wdat[0];
   assign ack[0]      = bus0.o_ack;
   assign err[0]      = bus0.o_err;
   assign rdat[0]     = bus0.o_dat;

   assign bus3.i_cyc  = cyc[1];
   assign bus3.i_stb  = stb[1];
   assign bus3.i_we   = we[1];
   assign bus3.i_addr = addr[1];
   assign bus3.i_dat  = wdat[1];
   assign ack[1]      = bus3.o_ack;
   assign err[1]      = bus3.o_err;
   assign rdat[1]     = bus3.o_dat;

   dbus_ram #(.ADDR_W(12), .BASE(32'h0000_0000), .WAIT(0)) dut0 (
      .i_clk   (clock),
      .i_reset (reset),
      .bus     (bus0)
   );

   dbus_ram #(.ADDR_W(12), .BASE(32'h0000_0000), .WAIT(3)) dut3 (
      .i_clk   (clock),
      .i_reset (reset),
      .bus     (bus3)
   );

   // Free-running clock and a cycle counter used to timestamp responses.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   function automatic int waitOf(input int idx);
      return (idx == 0) ? 0 : 3;
   endfunction

   // Compare one DUT's outputs against the head of its scoreboard queue.
   task automatic checkOutput(input int idx);
      exp_t x;
      bit   have;
      logic a;
      logic e;
      logic [15:0] d;
      a = ack[idx];
      e = err[idx];
      d = rdat[idx];
      if (a || e) begin
         checks++;
         if (a && e) begin
            errors++;
            $display("[TB] FAIL ackErrBoth dut%0d got ack=%0b err=%0b want not both", idx, a, e);
         end
         have = 1'b0;
         if (idx == 0 && expQ0.size() > 0) begin
            x = expQ0.pop_front();
            have = 1'b1;
         end else if (idx == 1 && expQ1.size() > 0) begin
            x = expQ1.pop_front();
            have = 1'b1;
         end
         checks++;
         if (!have) begin
            errors++;
            $display("[TB] FAIL unexpectedResp dut%0d cycle %0d got ack=%0b err=%0b want none", idx, cycle, a, e);
         end else begin
            checks++;
            if (e !== x.isErr) begin
               errors++;
               $display("[TB] FAIL respKind dut%0d got err=%0b want err=%0b", idx, e, x.isErr);
            end
            checks++;
            if (cycle != x.cyc) begin
               errors++;
               $display("[TB] FAIL respCycle dut%0d got %0d want %0d", idx, cycle, x.cyc);
            end
            if (x.chkDat) begin
               checks++;
               if (d !== x.dat) begin
                  errors++;
                  $display("[TB] FAIL respData dut%0d got %h want %h", idx, d, x.dat);
               end
            end
         end
      end else begin
         checks++;
         if (d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL idleDat dut%0d got %h want 0000", idx, d);
         end
      end
   endtask

   // Per-instance monitors, sampling mid-cycle away from the active edge.
   always @(negedge clock) checkOutput(0);
   always @(negedge clock) checkOutput(1);

   // Issue one request (called just after a rising edge), queue its expected
   // response and hold the request until the response has been seen.
   task automatic applyStimulus(input int idx, input bit wr, input logic [1:0] s,
                                input logic [31:0] a, input logic [15:0] d,
                                input bit expErr, input bit chkDat,
                                input logic [15:0] expDat);
      exp_t x;
      bit   got;
      cyc[idx]  = 1'b1;
      we[idx]   = wr;
      stb[idx]  = s;
      addr[idx] = a;
      wdat[idx] = d;
      x.isErr   = expErr;
      x.chkDat  = chkDat;
      x.dat     = expDat;
      x.cyc     = cycle + 1 + waitOf(idx);
      if (idx == 0) expQ0.push_back(x);
      else          expQ1.push_back(x);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (ack[idx] || err[idx]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL respTimeout dut%0d addr %h got no response want one", idx, a);
         if (idx == 0 && expQ0.size() > 0) void'(expQ0.pop_back());
         if (idx == 1 && expQ1.size() > 0) void'(expQ1.pop_back());
      end
      @(posedge clock);
      #1;
      cyc[idx] = 1'b0;
      stb[idx] = 2'b00;
      we[idx]  = 1'b0;
   endtask

   task automatic checkQuiet(input int idx, input string name);
      checks++;
      if (ack[idx] !== 1'b0 || err[idx] !== 1'b0 || rdat[idx] !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL %s dut%0d got ack=%0b err=%0b dat=%h want 0 0 0000",
                  name, idx, ack[idx], err[idx], rdat[idx]);
      end
   endtask

   // Runaway guard: every wait is bounded, this only catches a stuck bench.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence with hand-computed expectations.
   initial begin
      checks = 0;
      errors = 0;
      cycle  = 0;
      reset  = 1'b1;
      cyc    = 2'b00;
      we     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         stb[i]  = 2'b00;
         addr[i] = 32'h0;
         wdat[i] = 16'h0;
      end
      repeat (3) @(posedge clock);
      #1;
      checkQuiet(0, "resetState");
      checkQuiet(1, "resetState");
      reset = 1'b0;

      $display("[TB] WAIT=0 instance");
      applyStimulus(0, 1, STB_WORD, 32'h0000_0010, 16'hBEEF, 0, 0, 16'h0);
      applyStimulus(0, 0, STB_WORD, 32'h0000_0010, 16'h0000, 0, 1, 16'hBEEF);
      applyStimulus(0, 1, STB_HI,   32'h0000_0010, 16'h12AA, 0, 0, 16'h0);
      applyStimulus(0, 1, STB_LO,   32'h0000_0011, 16'hAA34, 0, 0, 16'h0);
      applyStimulus(0, 0, STB_WORD, 32'h0000_0010, 16'h0000, 0, 1, 16'h1234);
      applyStimulus(0, 0, STB_LO,   32'h0000_0011, 16'h0000, 0, 1, 16'h1234);
      applyStimulus(0, 1, STB_WORD, 32'h0000_0000, 16'h0A0B, 0, 0, 16'h0);
      applyStimulus(0, 1, STB_WORD, 32'h0001_0000, 16'hFFFF, OOR_ERR, 1, 16'h0000);
      applyStimulus(0, 0, STB_WORD, 32'h0000_0000, 16'h0000, 0, 1, 16'h0A0B);
      applyStimulus(0, 0, STB_WORD, 32'h0001_0010, 16'h0000, OOR_ERR, 1, 16'h0000);
      applyStimulus(0, 1, STB_WORD, 32'h0000_0040, 16'hCAFE, 0, 0, 16'h0);
      applyStimulus(0, 0, STB_WORD, 32'h0000_0040, 16'h0000, 0, 1, 16'hCAFE);

      // cyc without any strobe is not a request
      cyc[0]  = 1'b1;
      stb[0]  = 2'b00;
      addr[0] = 32'h0000_0040;
      repeat (4) @(posedge clock);
      #1;
      cyc[0]  = 1'b0;

      // reset during the ACK cycle of a write: response vanishes, no write
      applyStimulus(0, 1, STB_WORD, 32'h0000_0030, 16'h3333, 0, 0, 16'h0);
      cyc[0]  = 1'b1;
      we[0]   = 1'b1;
      stb[0]  = STB_WORD;
      addr[0] = 32'h0000_0030;
      wdat[0] = 16'h7777;
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkQuiet(0, "resetInAck");
      cyc[0] = 1'b0;
      we[0]  = 1'b0;
      stb[0] = 2'b00;
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(0, 0, STB_WORD, 32'h0000_0030, 16'h0000, 0, 1, 16'h3333);

      $display("[TB] WAIT=3 instance");
      applyStimulus(1, 1, STB_WORD, 32'h0000_0020, 16'h1111, 0, 0, 16'h0);
      applyStimulus(1, 0, STB_WORD, 32'h0000_0020, 16'h0000, 0, 1, 16'h1111);

      // abort: cyc dropped during WAIT, no ack and no write
      cyc[1]  = 1'b1;
      we[1]   = 1'b1;
      stb[1]  = STB_WORD;
      addr[1] = 32'h0000_0020;
      wdat[1] = 16'h5555;
      @(posedge clock);
      #1;
      cyc[1] = 1'b0;
      we[1]  = 1'b0;
      stb[1] = 2'b00;
      repeat (3) @(posedge clock);
      #1;
      applyStimulus(1, 0, STB_WORD, 32'h0000_0020, 16'h0000, 0, 1, 16'h1111);
      applyStimulus(1, 1, STB_WORD, 32'h0000_0050, 16'h00C3, 0, 0, 16'h0);
      applyStimulus(1, 0, STB_HI,   32'h0000_0050, 16'h0000, 0, 1, 16'h00C3);
      applyStimulus(1, 0, STB_WORD, 32'h0001_0020, 16'h0000, OOR_ERR, 1, 16'h0000);

      // reset during WAIT of a write
      cyc[1]  = 1'b1;
      we[1]   = 1'b1;
      stb[1]  = STB_WORD;
      addr[1] = 32'h0000_0020;
      wdat[1] = 16'h9999;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkQuiet(1, "resetInWait");
      cyc[1] = 1'b0;
      we[1]  = 1'b0;
      stb[1] = 2'b00;
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1, 0, STB_WORD, 32'h0000_0020, 16'h0000, 0, 1, 16'h1111);

      repeat (6) @(posedge clock);
      #1;
      checks++;
      if (expQ0.size() != 0 || expQ1.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboardDrain got %0d/%0d pending want 0/0",
                  expQ0.size(), expQ1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbus_ram.md
# dbus_ram

Word-wide on-chip RAM that acts as the responder side of the CPU's 16-bit data/instruction bus. It serves the `cyc`/`stb[1:0]`/`we`/`addr`/`dat`/`ack` handshake that the CPU core initiates for instruction fetches and load/store accesses. It decodes an address window, applies byte-lane writes, and inserts a parameterised number of wait states. It returns exactly one acknowledge per accepted request.

## Interface

Parameters:
- `ADDR_W`, default 12: word-address bits; depth is 2^ADDR_W 16-bit words.
- `BASE`, default 32'h0000_0000: byte base address of the window; must be aligned to 2^(ADDR_W+1).
- `WAIT`, default 0: wait states inserted before ack; legal range 0..15.

Ports:
- `i_clk` in 1: clock. Single clock domain, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_cyc` in 1: bus cycle active.
- `i_stb` in 2: byte strobes; bit1 selects `dat[15:8]`, bit0 selects `dat[7:0]`.
- `i_we` in 1: 1 = write, 0 = read.
- `i_addr` in 32: byte address; bit 0 is ignored, and the word index is `i_addr[ADDR_W:1]`.
- `i_dat` in 16: write data.
- `o_dat` out 16: read data; valid only while `o_ack` is high, 0 otherwise.
- `o_ack` out 1: one-cycle acknowledge.
- `o_err` out 1: one-cycle error response; constant 0 unless `DBUS_RAM_ERR_EN` is defined.

## Operation

- A request is present when `i_cyc && |i_stb`.
- The address is in range when `i_addr[31:ADDR_W+1] == BASE[31:ADDR_W+1]`.
- State machine:
  - IDLE: when a request is present, latch addr/we/stb/dat and the in-range flag. Go to WAIT if `WAIT>0`, else go to ACK.
  - WAIT: count down from WAIT-1. At 0, go to ACK. If `i_cyc` drops, go to IDLE with no ack and no write (abort).
  - ACK: drive `o_ack=1` (or `o_err=1`, see Configuration) for exactly one cycle, then go to IDLE unconditionally.
- Writes:
  - Only strobed lanes are written. Unstrobed lanes keep their contents.
  - The write commits on the edge that ends the ACK cycle, using the latched values.
- Reads:
  - Synchronous: the array is read on the edge that enters ACK.
  - `o_dat` returns the full word regardless of `i_stb`; the master selects the lane.
- Out-of-range access without the macro: acknowledged normally, `o_dat=0`, write discarded.
- Inputs are sampled only in IDLE. A request held high through ACK is not re-accepted until the following IDLE cycle.
- Reset:
  - Outputs go to `o_ack=0`, `o_err=0`, `o_dat=0`; state goes to IDLE; the wait counter goes to 0.
  - RAM contents are not reset.
  - Reset mid-transaction abandons the transaction; a pending write is never committed.

## Timing

- Request first sampled in IDLE at cycle N → `o_ack` high in cycle N+1+WAIT, for exactly one cycle.
- Back-to-back throughput: one transfer per 2+WAIT cycles. The cycle after ACK is always IDLE.
- Read data is registered and presented in the same cycle as `o_ack`.
- A write committed at the end of ACK is visible to a read accepted in the following IDLE cycle.
- Reset is asynchronous in assertion. Release is synchronous to `i_clk`: the first request can be sampled on the first edge after deassertion.

## Configuration

- `DBUS_RAM_ERR_EN` defined:
  - An out-of-range access ends with `o_err=1` instead of `o_ack=1`, in the same cycle position N+1+WAIT.
  - No write is performed, and `o_dat=0`.
  - `o_ack` and `o_err` are never high together.
- `DBUS_RAM_ERR_EN` undefined:
  - `o_err` is tied to 0.
  - Out-of-range accesses are acknowledged with `o_dat=0` and have no side effect.

## Structure

- Shared package `dbus_pkg`:
  - State encoding (IDLE/WAIT/ACK).
  - Lane constants `STB_HI=2'b10`, `STB_LO=2'b01`, `STB_WORD=2'b11`.
  - Bus data width constant (16).
- Sub-module `dbus_ram_array`:
  - 2^ADDR_W × 16 storage with per-byte write enables and a registered read port.
  - Keeps the storage inferable as block RAM.
- Top level holds the FSM, wait counter, address decode and response muxing.

## Test plan

- WAIT=0: write 0xBEEF, stb=11, addr 0x0010 → ack in cycle N+1. Read 0x0010 → ack in cycle N+1 with `o_dat=0xBEEF`.
- Byte lanes: write stb=10 dat=0x12AA to 0x0010, then stb=01 dat=0xAA34 → read returns 0x1234. Addr 0x0011 aliases 0x0010.
- WAIT=3: read request at cycle N → `o_ack` high only in cycle N+4. Requests held back-to-back are acked every 5 cycles.
- Abort: drop `i_cyc` during WAIT on a write of 0x5555 to 0x0020 → no ack; a later read of 0x0020 returns the old value.
- Out of range: addr 0x0001_0000, BASE=0, ADDR_W=12, write 0xFFFF.
  - With macro: `o_err` for one cycle, no ack.
  - Without macro: ack with `o_dat=0`.
  - In both cases the in-window word at 0x0000 is unchanged.
- Assert `i_reset` during WAIT of a write → `o_ack`/`o_err`/`o_dat` go 0 immediately. After release, the next read is acked at N+1+WAIT and the aborted write did not land.
